// File: rtl/axis_fifo_arbiter.sv
// axis_fifo_arbiter: round-robin packet arbiter feeding a downstream FIFO write port
// Ports:
//   clk_i, reset_ni            clock and asynchronous active-low reset
//   s_axis_in_*                per-requester AXI-Stream inputs, port i in slice i
//   fifo_full_i, fifo_level_i  downstream FIFO flags used to throttle acceptance
//   m_axis_out_*               registered FIFO write beat, tid = source port
//   grant_o                    one-hot owner of the output while a packet is open
//   pkt_abort_o                pulse with the beat that force-terminates a packet
module axis_fifo_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int USER_WIDTH  = 1,
    parameter int NUM_PORTS   = 2,
    parameter int FIFO_LEN    = 8,
    parameter int MARGIN      = 2,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_in_tdata,
    input  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_in_tuser,
    input  logic [NUM_PORTS-1:0]            s_axis_in_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_in_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_in_tready,
    input  logic                            fifo_full_i,
    input  logic [$clog2(FIFO_LEN)-1:0]     fifo_level_i,
    output logic [DATA_WIDTH-1:0]           m_axis_out_tdata,
    output logic [USER_WIDTH-1:0]           m_axis_out_tuser,
    output logic [$clog2(NUM_PORTS)-1:0]    m_axis_out_tid,
    output logic                            m_axis_out_tlast,
    output logic                            m_axis_out_tvalid,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            pkt_abort_o
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic          state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] cur;
    logic [IW-1:0] nxt;
    logic [CW-1:0] cnt;
    logic          found;
    logic          stall;
    logic          accept;
    logic          force_last;
    logic          end_pkt;

    // The FIFO flags are registered downstream, so MARGIN entries are kept free.
    assign stall = fifo_full_i || (int'(fifo_level_i) >= FIFO_LEN - MARGIN);

    // First requester at or after last_grant+1, wrapping.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!found && s_axis_in_tvalid[(int'(last_grant) + k) % NUM_PORTS]) begin
                nxt   = IW'((int'(last_grant) + k) % NUM_PORTS);
                found = 1'b1;
            end
        end
    end

    assign s_axis_in_tready = (state == BUSY && !stall) ? grant_o : '0;
    assign accept           = s_axis_in_tvalid[cur] && s_axis_in_tready[cur];
    assign force_last       = cnt == CW'(MAX_PKT_LEN - 1);
    assign end_pkt          = s_axis_in_tlast[cur] || force_last;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state             <= IDLE;
            last_grant        <= IW'(NUM_PORTS - 1);
            cur               <= '0;
            grant_o           <= '0;
            cnt               <= '0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            pkt_abort_o       <= 1'b0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= '0;
            m_axis_out_tid    <= '0;
        end else begin
            m_axis_out_tvalid <= accept;
            pkt_abort_o       <= accept && force_last && !s_axis_in_tlast[cur];
            if (state == IDLE) begin
                if (found) begin
                    state   <= BUSY;
                    cur     <= nxt;
                    grant_o <= NUM_PORTS'(1) << nxt;
                    cnt     <= '0;
                end
            end else if (accept) begin
                cnt              <= cnt + 1'b1;
                m_axis_out_tdata <= s_axis_in_tdata[cur*DATA_WIDTH +: DATA_WIDTH];
                m_axis_out_tuser <= s_axis_in_tuser[cur*USER_WIDTH +: USER_WIDTH];
                m_axis_out_tid   <= cur;
                m_axis_out_tlast <= end_pkt;
                // Releasing the grant here leaves one idle cycle before the next packet.
                if (end_pkt) begin
                    state      <= IDLE;
                    grant_o    <= '0;
                    last_grant <= cur;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// tb_axis_fifo_arbiter: directed vector bench for axis_fifo_arbiter
module tb_axis_fifo_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] s_axis_in_tdata;
    logic [1:0]  s_axis_in_tuser;
    logic [1:0]  s_axis_in_tvalid;
    logic [1:0]  s_axis_in_tlast;
    logic [1:0]  s_axis_in_tready;
    logic        fifo_full_i;
    logic [2:0]  fifo_level_i;
    logic [15:0] m_axis_out_tdata;
    logic [0:0]  m_axis_out_tuser;
    logic [0:0]  m_axis_out_tid;
    logic        m_axis_out_tlast;
    logic        m_axis_out_tvalid;
    logic [1:0]  grant_o;
    logic        pkt_abort_o;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0]  tv, tl;
        logic [15:0] d0, d1;
        logic [2:0]  lvl;
        logic        full;
        logic [1:0]  rdy, gnt;
        logic        ov, ab, tid, last;
        logic [15:0] od;
    } vec_t;

    vec_t v[38];

    axis_fifo_arbiter #(
        .DATA_WIDTH(16), .USER_WIDTH(1), .NUM_PORTS(2),
        .FIFO_LEN(8), .MARGIN(2), .MAX_PKT_LEN(4)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tuser(s_axis_in_tuser),
        .s_axis_in_tvalid(s_axis_in_tvalid), .s_axis_in_tlast(s_axis_in_tlast),
        .s_axis_in_tready(s_axis_in_tready),
        .fifo_full_i(fifo_full_i), .fifo_level_i(fifo_level_i),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tuser(m_axis_out_tuser),
        .m_axis_out_tid(m_axis_out_tid), .m_axis_out_tlast(m_axis_out_tlast),
        .m_axis_out_tvalid(m_axis_out_tvalid), .grant_o(grant_o),
        .pkt_abort_o(pkt_abort_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic [1:0] tv, tl, input logic [15:0] d0, d1,
                                input logic [2:0] lvl, input logic full,
                                input logic [1:0] rdy, gnt, input logic ov, ab, tid, last,
                                input logic [15:0] od);
        vec_t r;
        r.tv = tv; r.tl = tl; r.d0 = d0; r.d1 = d1; r.lvl = lvl; r.full = full;
        r.rdy = rdy; r.gnt = gnt; r.ov = ov; r.ab = ab; r.tid = tid; r.last = last; r.od = od;
        return r;
    endfunction

    // Port p drives tuser = p, so the output tuser must always track tid.
    task automatic check(input string nm, input logic [1:0] rdy, gnt, input logic ov, ab, tid, last,
                         input logic [15:0] od, input bit full);
        logic [24:0] got, exp, mask;
        got  = {s_axis_in_tready, grant_o, m_axis_out_tvalid, pkt_abort_o, m_axis_out_tid,
                m_axis_out_tuser, m_axis_out_tlast, m_axis_out_tdata};
        exp  = {rdy, gnt, ov, ab, tid, tid, last, od};
        mask = (ov || full) ? '1 : 25'h1F80000;
        n_vec++;
        if ((got & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s: got rdy/gnt/ov/ab/tid/user/last/data=%h expected %h (mask %h)",
                     nm, got & mask, exp & mask, mask);
        end
    endtask

    initial begin
        //        tv     tl     d0        d1        lvl  full  rdy    gnt    ov ab tid last od
        v[0]  = mk(2'b11, 2'b00, 16'hA000, 16'hB000, 3'd0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000);
        v[1]  = mk(2'b11, 2'b00, 16'hA000, 16'hB000, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[2]  = mk(2'b11, 2'b00, 16'hA001, 16'hB000, 3'd0, 1'b0, 2'b01, 2'b01, 1, 0, 0, 0, 16'hA000);
        v[3]  = mk(2'b11, 2'b01, 16'hA002, 16'hB000, 3'd0, 1'b0, 2'b01, 2'b01, 1, 0, 0, 0, 16'hA001);
        v[4]  = mk(2'b11, 2'b00, 16'hA010, 16'hB000, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 0, 1, 16'hA002);
        v[5]  = mk(2'b11, 2'b00, 16'hA010, 16'hB000, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[6]  = mk(2'b11, 2'b00, 16'hA010, 16'hB001, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hB000);
        v[7]  = mk(2'b11, 2'b10, 16'hA010, 16'hB002, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hB001);
        v[8]  = mk(2'b11, 2'b00, 16'hA010, 16'hB010, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 1, 1, 16'hB002);
        v[9]  = mk(2'b11, 2'b00, 16'hA010, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[10] = mk(2'b11, 2'b00, 16'hA011, 16'hB010, 3'd6, 1'b0, 2'b00, 2'b01, 1, 0, 0, 0, 16'hA010);
        v[11] = mk(2'b11, 2'b00, 16'hA011, 16'hB010, 3'd6, 1'b0, 2'b00, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[12] = mk(2'b11, 2'b00, 16'hA011, 16'hB010, 3'd0, 1'b1, 2'b00, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[13] = mk(2'b11, 2'b00, 16'hA011, 16'hB010, 3'd5, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[14] = mk(2'b11, 2'b01, 16'hA012, 16'hB010, 3'd5, 1'b0, 2'b01, 2'b01, 1, 0, 0, 0, 16'hA011);
        v[15] = mk(2'b01, 2'b00, 16'hA020, 16'hB010, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 0, 1, 16'hA012);
        v[16] = mk(2'b01, 2'b00, 16'hA020, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[17] = mk(2'b10, 2'b00, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 1, 0, 0, 0, 16'hA020);
        v[18] = mk(2'b10, 2'b00, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[19] = mk(2'b10, 2'b00, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[20] = mk(2'b11, 2'b11, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000);
        v[21] = mk(2'b10, 2'b10, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 0, 1, 16'hA021);
        v[22] = mk(2'b10, 2'b10, 16'hA021, 16'hB010, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[23] = mk(2'b10, 2'b10, 16'hA021, 16'hB011, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 1, 1, 16'hB010);
        v[24] = mk(2'b10, 2'b10, 16'hA021, 16'hB011, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[25] = mk(2'b10, 2'b10, 16'hA021, 16'hB012, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 1, 1, 16'hB011);
        v[26] = mk(2'b10, 2'b10, 16'hA021, 16'hB012, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[27] = mk(2'b00, 2'b00, 16'hA021, 16'hB012, 3'd0, 1'b0, 2'b00, 2'b00, 1, 0, 1, 1, 16'hB012);
        v[28] = mk(2'b00, 2'b00, 16'hA021, 16'hB012, 3'd0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000);
        v[29] = mk(2'b10, 2'b00, 16'hA021, 16'hC000, 3'd0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000);
        v[30] = mk(2'b10, 2'b00, 16'hA021, 16'hC000, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[31] = mk(2'b10, 2'b00, 16'hA021, 16'hC001, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hC000);
        v[32] = mk(2'b10, 2'b00, 16'hA021, 16'hC002, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hC001);
        v[33] = mk(2'b10, 2'b00, 16'hA021, 16'hC003, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hC002);
        v[34] = mk(2'b10, 2'b00, 16'hA021, 16'hC004, 3'd0, 1'b0, 2'b00, 2'b00, 1, 1, 1, 1, 16'hC003);
        v[35] = mk(2'b10, 2'b00, 16'hA021, 16'hC004, 3'd0, 1'b0, 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000);
        v[36] = mk(2'b10, 2'b00, 16'hA021, 16'hC005, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hC004);
        v[37] = mk(2'b00, 2'b00, 16'hA021, 16'hC005, 3'd0, 1'b0, 2'b10, 2'b10, 1, 0, 1, 0, 16'hC005);

        s_axis_in_tdata  = '0;
        s_axis_in_tuser  = 2'b10;
        s_axis_in_tvalid = '0;
        s_axis_in_tlast  = '0;
        fifo_full_i      = 1'b0;
        fifo_level_i     = '0;
        reset_ni         = 1'b1;
        #1 reset_ni      = 1'b0;
        repeat (2) @(negedge clk_i);
        #1 check("reset_state", 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 1);

        for (int i = 0; i < 38; i++) begin
            @(negedge clk_i);
            reset_ni         = 1'b1;
            s_axis_in_tvalid = v[i].tv;
            s_axis_in_tlast  = v[i].tl;
            s_axis_in_tdata  = {v[i].d1, v[i].d0};
            fifo_level_i     = v[i].lvl;
            fifo_full_i      = v[i].full;
            #1 check($sformatf("vec%0d", i), v[i].rdy, v[i].gnt, v[i].ov, v[i].ab,
                     v[i].tid, v[i].last, v[i].od, 0);
        end

        // Port 1 packet still open with two beats accepted; reset mid-packet.
        @(negedge clk_i);
        s_axis_in_tvalid = 2'b10;
        s_axis_in_tlast  = 2'b00;
        s_axis_in_tdata  = {16'hC006, 16'hA021};
        #1 check("pre_rst_open", 2'b10, 2'b10, 0, 0, 0, 0, 16'h0000, 0);
        @(posedge clk_i);
        #2 check("pre_rst_beat", 2'b10, 2'b10, 1, 0, 1, 0, 16'hC006, 0);
        reset_ni = 1'b0;
        #1 check("async_rst", 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 1);
        s_axis_in_tvalid = 2'b11;
        s_axis_in_tdata  = {16'hC007, 16'hD000};
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1 check("post_rst_idle", 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 1);
        @(negedge clk_i);
        #1 check("post_rst_grant", 2'b01, 2'b01, 0, 0, 0, 0, 16'h0000, 0);
        @(negedge clk_i);
        #1 check("post_rst_beat", 2'b01, 2'b01, 1, 0, 0, 0, 16'hD000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
